// File: rtl/svm_lin_seq_mac.sv
// ---------------------------------------------------------------------------
// svm_lin_seq_mac
// Sequential linear SVM regressor. It computes
//   y = INTERCEPT + sum_i w_i * x_i
// over N_FEAT unsigned features with one multiply-accumulate unit, one feature
// per clock. The raw sum feeds a saturating output and a sign-based class bit.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   clr        synchronous abort: back to IDLE, in-flight result dropped
//   inp        packed features, feature i at inp[i*IN_W +: IN_W]
//   in_valid   inp is valid
//   in_ready   block can accept a vector (IDLE only)
//   out        saturated signed result
//   out_cls    class decision, 1 when the result is >= 0
//   out_valid  out/out_cls are valid (DONE only)
//   out_ready  consumer accepts the result
// ---------------------------------------------------------------------------
module svm_lin_seq_mac #(
    parameter int                      N_FEAT    = 11,
    parameter int                      IN_W      = 4,
    parameter int                      W_W       = 8,
    parameter logic [N_FEAT*W_W-1:0]   WEIGHTS   = {8'sd25, 8'sd10, 8'sd11, -8'sd74,
                                                    -8'sd6, 8'sd13, -8'sd2, 8'sd59,
                                                    -8'sd3, -8'sd29, 8'sd4},
    parameter int                      INTERCEPT = 1357,
    parameter int                      ACC_W     = 20,
    parameter int                      OUT_W     = 13
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic [N_FEAT*IN_W-1:0]   inp,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic signed [OUT_W-1:0]  out,
    output logic                     out_cls,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam int IDX_W     = $clog2(N_FEAT);
    localparam int PROD_W    = IN_W + W_W + 1;
    localparam int SAT_MAX_I = (1 << (OUT_W - 1)) - 1;

    localparam logic signed [ACC_W-1:0] ACC_INIT = ACC_W'(INTERCEPT);
    localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'(SAT_MAX_I);
    localparam logic signed [ACC_W-1:0] SAT_MIN  = ACC_W'(-SAT_MAX_I - 1);
    localparam logic [IDX_W-1:0]        IDX_LAST = IDX_W'(N_FEAT - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                     state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic [N_FEAT*IN_W-1:0]     feat_q, feat_d;
    logic signed [OUT_W-1:0]    out_q, out_d;
    logic                       cls_q, cls_d;

    // MAC datapath
    logic [IN_W-1:0]            x_cur;
    logic [W_W-1:0]             w_cur;
    logic signed [PROD_W-1:0]   x_ext, w_ext, prod;
    logic signed [ACC_W-1:0]    acc_mac;
    logic signed [OUT_W-1:0]    sat_val;

    always_comb begin
        x_cur = feat_q[idx_q*IN_W +: IN_W];
        w_cur = WEIGHTS[idx_q*W_W +: W_W];
        // Feature is zero-extended (unsigned), weight sign-extended; PROD_W
        // bits hold the exact product.
        x_ext = {{W_W{1'b0}}, x_cur};
        w_ext = {{(IN_W+1){w_cur[W_W-1]}}, w_cur};
        prod  = x_ext * w_ext;
        acc_mac = acc_q + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

        if (acc_mac > SAT_MAX)      sat_val = SAT_MAX[OUT_W-1:0];
        else if (acc_mac < SAT_MIN) sat_val = SAT_MIN[OUT_W-1:0];
        else                        sat_val = acc_mac[OUT_W-1:0];
    end

    // Next-state and datapath update.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned; that is what keeps this block free of latches.
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        feat_d  = feat_q;
        out_d   = out_q;
        cls_d   = cls_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    feat_d  = inp;
                    acc_d   = ACC_INIT;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = acc_mac;
                if (idx_q == IDX_LAST) begin
                    // Result is captured on the DONE entry edge and held there.
                    out_d   = sat_val;
                    cls_d   = ~acc_mac[ACC_W-1];
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Abort wins over every transition; the visible result registers keep
        // their old value, which is harmless because out_valid drops.
        if (clr) begin
            state_d = IDLE;
            acc_d   = '0;
            idx_d   = '0;
            out_d   = out_q;
            cls_d   = cls_q;
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update
    // together from values sampled before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            feat_q  <= '0;
            out_q   <= '0;
            cls_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            feat_q  <= feat_d;
            out_q   <= out_d;
            cls_q   <= cls_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out       = out_q;
    assign out_cls   = cls_q;

endmodule

// File: tb/tb_svm_lin_seq_mac.sv
// ---------------------------------------------------------------------------
// tb_svm_lin_seq_mac
// Directed bench for svm_lin_seq_mac. Three instances share the stimulus:
// dut0 uses the default intercept, dut1 uses +4000 and dut2 uses -4000 so the
// saturation limits can be reached. Inputs change 1 time unit after a rising
// edge; outputs are sampled at that same point, away from the edge.
// Weights (index 0..10): 4, -29, -3, 59, -2, 13, -6, -74, 11, 10, 25.
// ---------------------------------------------------------------------------
module tb_svm_lin_seq_mac;

    localparam int N_FEAT = 11;
    localparam int IN_W   = 4;
    localparam int OUT_W  = 13;
    localparam int VEC_W  = N_FEAT * IN_W;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    clr;
    logic [VEC_W-1:0]        inp;
    logic                    in_valid;
    logic                    out_ready;

    logic                    in_ready0, in_ready1, in_ready2;
    logic                    out_valid0, out_valid1, out_valid2;
    logic signed [OUT_W-1:0] out0, out1, out2;
    logic                    cls0, cls1, cls2;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    svm_lin_seq_mac dut0 (
        .clk(clk), .rst(rst), .clr(clr), .inp(inp), .in_valid(in_valid),
        .in_ready(in_ready0), .out(out0), .out_cls(cls0),
        .out_valid(out_valid0), .out_ready(out_ready)
    );

    svm_lin_seq_mac #(.INTERCEPT(4000)) dut1 (
        .clk(clk), .rst(rst), .clr(clr), .inp(inp), .in_valid(in_valid),
        .in_ready(in_ready1), .out(out1), .out_cls(cls1),
        .out_valid(out_valid1), .out_ready(out_ready)
    );

    svm_lin_seq_mac #(.INTERCEPT(-4000)) dut2 (
        .clk(clk), .rst(rst), .clr(clr), .inp(inp), .in_valid(in_valid),
        .in_ready(in_ready2), .out(out2), .out_cls(cls2),
        .out_valid(out_valid2), .out_ready(out_ready)
    );

    // Vector with feature i set to 15, all others 0.
    function automatic logic [VEC_W-1:0] one_hot15(input int i);
        logic [VEC_W-1:0] v;
        v = '0;
        v[i*IN_W +: IN_W] = 4'hF;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accepts vec, waits for out_valid on dut0 (bounded), returns the results
    // of all three instances and the cycle count from the accept edge. Leaves
    // the instances in DONE with out_ready low.
    task automatic issue(input logic [VEC_W-1:0] vec, output int lat);
        inp      = vec;
        in_valid = 1'b1;
        tests++;
        if (in_ready0 !== 1'b1) begin
            failed++;
            $display("FAIL issue_in_ready: got %b expected 1", in_ready0);
        end
        step();
        in_valid = 1'b0;
        lat = 0;
        do begin
            step();
            lat++;
        end while (out_valid0 !== 1'b1 && lat < 40);
        tests++;
        if (out_valid0 !== 1'b1) begin
            failed++;
            $display("FAIL issue_timeout: out_valid not seen within %0d cycles", lat);
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; clr = 1'b0; inp = '0; in_valid = 1'b0; out_ready = 1'b0;
        step();
        tests += 4;
        if (in_ready0 !== 1'b1) begin failed++; $display("FAIL reset_in_ready: got %b expected 1", in_ready0); end
        if (out_valid0 !== 1'b0) begin failed++; $display("FAIL reset_out_valid: got %b expected 0", out_valid0); end
        if (out0 !== 13'sd0) begin failed++; $display("FAIL reset_out: got %0d expected 0", out0); end
        if (cls0 !== 1'b0) begin failed++; $display("FAIL reset_out_cls: got %b expected 0", cls0); end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_zero();
        int lat;
        issue('0, lat);
        tests += 3;
        if (lat != 11) begin failed++; $display("FAIL zero_latency: got %0d expected 11", lat); end
        if (out0 !== 13'sd1357) begin failed++; $display("FAIL zero_out: got %0d expected 1357", out0); end
        if (cls0 !== 1'b1) begin failed++; $display("FAIL zero_cls: got %b expected 1", cls0); end
        release_result();
        tests += 2;
        if (in_ready0 !== 1'b1) begin failed++; $display("FAIL zero_idle_in_ready: got %b expected 1", in_ready0); end
        if (out_valid0 !== 1'b0) begin failed++; $display("FAIL zero_idle_out_valid: got %b expected 0", out_valid0); end
    endtask

    task automatic test_all15();
        int lat;
        issue({VEC_W{1'b1}}, lat);
        tests++;
        if (out0 !== 13'sd1477) begin failed++; $display("FAIL all15_out: got %0d expected 1477", out0); end
        release_result();
    endtask

    task automatic test_features();
        int lat;
        issue(one_hot15(7), lat);
        tests += 2;
        if (out0 !== 13'sd247) begin failed++; $display("FAIL f7_out: got %0d expected 247", out0); end
        if (cls0 !== 1'b1) begin failed++; $display("FAIL f7_cls: got %b expected 1", cls0); end
        release_result();
        issue(one_hot15(7) | one_hot15(1), lat);
        tests += 2;
        if (out0 !== -13'sd188) begin failed++; $display("FAIL f7f1_out: got %0d expected -188", out0); end
        if (cls0 !== 1'b0) begin failed++; $display("FAIL f7f1_cls: got %b expected 0", cls0); end
        release_result();
    endtask

    task automatic test_saturation();
        int lat;
        issue(one_hot15(3), lat);
        tests += 3;
        if (out0 !== 13'sd2242) begin failed++; $display("FAIL f3_out: got %0d expected 2242", out0); end
        if (out1 !== 13'sd4095) begin failed++; $display("FAIL sat_hi_out: got %0d expected 4095", out1); end
        if (cls1 !== 1'b1) begin failed++; $display("FAIL sat_hi_cls: got %b expected 1", cls1); end
        release_result();
        issue(one_hot15(7), lat);
        tests += 2;
        if (out2 !== -13'sd4096) begin failed++; $display("FAIL sat_lo_out: got %0d expected -4096", out2); end
        if (cls2 !== 1'b0) begin failed++; $display("FAIL sat_lo_cls: got %b expected 0", cls2); end
        release_result();
    endtask

    // inp changes and in_valid held during RUN/DONE must not disturb the result.
    task automatic test_inp_ignored();
        int lat;
        inp      = one_hot15(7);
        in_valid = 1'b1;
        step();
        inp = {VEC_W{1'b1}};
        lat = 0;
        while (out_valid0 !== 1'b1 && lat < 40) begin
            tests++;
            if (in_ready0 !== 1'b0) begin failed++; $display("FAIL ignore_in_ready: got %b expected 0", in_ready0); end
            step();
            lat++;
        end
        tests += 2;
        if (lat != 11) begin failed++; $display("FAIL ignore_latency: got %0d expected 11", lat); end
        if (out0 !== 13'sd247) begin failed++; $display("FAIL ignore_out: got %0d expected 247", out0); end
        in_valid = 1'b0;
        release_result();
    endtask

    task automatic test_back_to_back();
        int lat;
        issue(one_hot15(0), lat);
        for (int c = 0; c < 5; c++) begin
            step();
            tests += 3;
            if (out0 !== 13'sd1417) begin failed++; $display("FAIL bp_out cycle %0d: got %0d expected 1417", c, out0); end
            if (out_valid0 !== 1'b1) begin failed++; $display("FAIL bp_out_valid cycle %0d: got %b expected 1", c, out_valid0); end
            if (in_ready0 !== 1'b0) begin failed++; $display("FAIL bp_in_ready cycle %0d: got %b expected 0", c, in_ready0); end
        end
        release_result();
        tests++;
        if (in_ready0 !== 1'b1) begin failed++; $display("FAIL b2b_idle: got %b expected 1", in_ready0); end
        issue({VEC_W{1'b1}}, lat);
        tests += 2;
        if (lat != 11) begin failed++; $display("FAIL b2b_latency: got %0d expected 11", lat); end
        if (out0 !== 13'sd1477) begin failed++; $display("FAIL b2b_out: got %0d expected 1477", out0); end
        release_result();
    endtask

    task automatic test_abort();
        int lat;
        // Synchronous clr with idx == 5 (accept edge + 5 MAC edges).
        inp = {VEC_W{1'b1}};
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (5) step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        tests += 2;
        if (in_ready0 !== 1'b1) begin failed++; $display("FAIL clr_in_ready: got %b expected 1", in_ready0); end
        if (out_valid0 !== 1'b0) begin failed++; $display("FAIL clr_out_valid: got %b expected 0", out_valid0); end
        repeat (10) begin
            step();
            tests++;
            if (out_valid0 !== 1'b0) begin failed++; $display("FAIL clr_no_result: got %b expected 0", out_valid0); end
        end
        issue('0, lat);
        tests++;
        if (out0 !== 13'sd1357) begin failed++; $display("FAIL clr_next_out: got %0d expected 1357", out0); end
        release_result();

        // Asynchronous rst mid-RUN, observed before the next clock edge.
        inp = {VEC_W{1'b1}};
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        #1;
        tests += 2;
        if (in_ready0 !== 1'b1) begin failed++; $display("FAIL rst_in_ready: got %b expected 1", in_ready0); end
        if (out_valid0 !== 1'b0) begin failed++; $display("FAIL rst_out_valid: got %b expected 0", out_valid0); end
        step();
        rst = 1'b0;
        step();
        issue('0, lat);
        tests++;
        if (out0 !== 13'sd1357) begin failed++; $display("FAIL rst_next_out: got %0d expected 1357", out0); end
        release_result();
    endtask

    initial begin
        test_reset();
        test_zero();
        test_all15();
        test_features();
        test_saturation();
        test_inp_ignored();
        test_back_to_back();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
